// File: rtl/cla4_adder_if.sv
// Operand/result bundle for the 4-bit lookahead adder slice.
// The master drives operands; the slave returns the registered sum and group terms.
interface cla4_adder_if;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       in_valid;
    logic [3:0] y;
    logic       cout;
    logic       grp_p;
    logic       grp_g;
    logic       out_valid;

    modport master (
        output a, b, cin, in_valid,
        input  y, cout, grp_p, grp_g, out_valid
    );

    modport slave (
        input  a, b, cin, in_valid,
        output y, cout, grp_p, grp_g, out_valid
    );
endinterface

// File: rtl/cla4_adder.sv
// 4-bit carry-lookahead adder with a single registered output stage.
// Group p/g are exported so slices can cascade under a higher-level lookahead unit.
module cla4_adder (
    input  logic         clk,
    input  logic         rst,
    cla4_adder_if.slave  bus
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] s;
    logic       gp;
    logic       gg;

    assign g = bus.a & bus.b;
    assign p = bus.a ^ bus.b;

    // Every carry is a flat sum-of-products; no carry feeds another carry.
    assign c[0] = bus.cin;
    assign c[1] = g[0] | (p[0] & bus.cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bus.cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & bus.cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & bus.cin);

    assign s  = p ^ c[3:0];
    assign gp = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

    // Data registers load only on qualified cycles, so X on idle inputs never lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.y         <= 4'd0;
            bus.cout      <= 1'b0;
            bus.grp_p     <= 1'b0;
            bus.grp_g     <= 1'b0;
            bus.out_valid <= 1'b0;
        end else if (bus.in_valid) begin
            bus.y         <= s;
            bus.cout      <= c[4];
            bus.grp_p     <= gp;
            bus.grp_g     <= gg;
            bus.out_valid <= 1'b1;
        end else begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cla4_adder.sv
// Bench for cla4_adder: arithmetic reference model checked every cycle,
// plus hand-computed literal expectations on the directed vectors.
module tb_cla4_adder;
    logic clk;
    logic rst;
    cla4_adder_if bus();

    cla4_adder dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the sampled operands.
    logic [4:0] exp_sum;
    logic       exp_p, exp_g, exp_v, exp_cin, mdl_init;
    initial mdl_init = 1'b0;

    always @(posedge clk) begin
        mdl_init <= 1'b1;
        if (rst) begin
            exp_sum <= 5'd0;
            exp_p   <= 1'b0;
            exp_g   <= 1'b0;
            exp_v   <= 1'b0;
            exp_cin <= 1'b0;
        end else if (bus.in_valid) begin
            exp_sum <= 5'(bus.a) + 5'(bus.b) + 5'(bus.cin);
            exp_p   <= ((bus.a ^ bus.b) == 4'hF);
            exp_g   <= ((5'(bus.a) + 5'(bus.b)) > 5'd15);
            exp_v   <= 1'b1;
            exp_cin <= bus.cin;
        end else begin
            exp_v   <= 1'b0;
        end
    end

    int         n_chk = 0;
    int         n_fail = 0;
    int         lit_tag = 0;
    int         lit_seen = 0;
    string      lit_name;
    logic [7:0] lit_exp;
    logic       done = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b at %0t", nm, act, req, $time);
        end
    endtask

    // Single compare process: model check every cycle, literal check when posted.
    initial forever begin
        @(negedge clk);
        if (mdl_init && !done) begin
            chk("out_valid", {7'd0, bus.out_valid}, {7'd0, exp_v});
            chk("sum", {3'd0, bus.cout, bus.y}, {3'd0, exp_sum});
            chk("grp_pg", {6'd0, bus.grp_p, bus.grp_g}, {6'd0, exp_p, exp_g});
            if (exp_v)
                chk("c4_rel", {7'd0, bus.cout}, {7'd0, bus.grp_g | (bus.grp_p & exp_cin)});
        end
        if (lit_tag != lit_seen) begin
            chk({"lit_", lit_name},
                {3'd0, bus.out_valid, bus.cout, bus.grp_p, bus.grp_g, bus.y[0]},
                {3'd0, lit_exp[7:4], lit_exp[0]});
            chk({"lit_", lit_name, "_y"}, {4'd0, bus.y}, {4'd0, lit_exp[3:0]});
            lit_seen = lit_tag;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string nm, input logic v, input logic c,
                       input logic p, input logic g, input logic [3:0] yy);
        lit_name = nm;
        lit_exp  = {v, c, p, g, yy};
        lit_tag++;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b,
                         input logic ci, input logic v);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = ci;
        bus.in_valid = v;
    endtask

    initial begin
        rst = 1'b1;
        drive(4'hF, 4'hF, 1'b1, 1'b1);
        tick(); lit("rst0", 0, 0, 0, 0, 4'h0);
        tick(); lit("rst1", 0, 0, 0, 0, 4'h0);
        rst = 1'b0;
        tick(); lit("first", 1, 1, 0, 1, 4'hF);

        drive(4'h0, 4'h0, 1'b0, 1'b1);
        tick(); lit("zero", 1, 0, 0, 0, 4'h0);
        drive(4'h4, 4'h3, 1'b1, 1'b1);
        tick(); lit("cin", 1, 0, 0, 0, 4'h8);
        drive(4'hC, 4'h3, 1'b0, 1'b1);
        tick(); lit("prop", 1, 0, 1, 0, 4'hF);
        drive(4'hC, 4'h3, 1'b1, 1'b1);
        tick(); lit("prop_c", 1, 1, 1, 0, 4'h0);
        drive(4'hF, 4'hF, 1'b1, 1'b1);
        tick(); lit("max", 1, 1, 0, 1, 4'hF);

        drive(4'h5, 4'h9, 1'b0, 1'b0);
        tick(); lit("hold0", 0, 1, 0, 1, 4'hF);
        drive(4'hA, 4'h2, 1'b1, 1'b0);
        tick(); lit("hold1", 0, 1, 0, 1, 4'hF);
        drive(4'h1, 4'h1, 1'b0, 1'b1);
        tick(); lit("one", 1, 0, 0, 0, 4'h2);
        rst = 1'b1;
        drive(4'h7, 4'h7, 1'b0, 1'b1);
        tick(); lit("rst_mid", 0, 0, 0, 0, 4'h0);
        rst = 1'b0;

        for (int i = 0; i < 512; i++) begin
            drive(i[3:0], i[7:4], i[8], 1'b1);
            tick();
        end
        lit("exh_last", 1, 1, 0, 1, 4'hF);

        bus.a        = 4'bx;
        bus.b        = 4'bx;
        bus.cin      = 1'bx;
        bus.in_valid = 1'b0;
        tick(); lit("x_idle", 0, 1, 0, 1, 4'hF);
        tick();

        @(negedge clk);
        done = 1'b1;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
